// File: rtl/core_mem_if.sv
// Request/response bus between the MEM stage and data memory.
// The MEM stage is the master: it holds a request until mem_ready.
interface core_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/core_mem.sv
// MEM pipeline stage: issues loads/stores, waits for the memory with a timeout,
// extracts and extends load lanes, and registers the writeback result.
package core_mem_pkg;
  typedef struct packed {
    logic [63:0] out;
    logic [63:0] store_data;
    logic [4:0]  W_regnum;
    logic        write_enable;
    logic [1:0]  mem_load_type;
    logic [1:0]  mem_store_type;
    logic        signed_byte;
    logic        signed_word;
  } EX_regs_t;

  localparam logic [1:0] MT_NONE  = 2'd0;
  localparam logic [1:0] MT_BYTE  = 2'd1;
  localparam logic [1:0] MT_WORD  = 2'd2;
  localparam logic [1:0] MT_DWORD = 2'd3;
endpackage

module core_mem
  import core_mem_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  EX_regs_t    EX_regs,
  input  logic        flush,
  core_mem_if.master  mem_bus,
  output logic        stall,
  output logic [63:0] MEM_data,
  output logic [4:0]  MEM_W_regnum,
  output logic        MEM_write_enable,
  output logic        addr_err,
  output logic        bus_err
);
  localparam int CNT_W = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(WAIT_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W:0]  cnt_inc;
  EX_regs_t        held_reg, held_next;
  logic [63:0]     data_reg, data_next;
  logic [4:0]      regnum_reg, regnum_next;
  logic            wen_reg, wen_next;
  logic            addr_err_reg, addr_err_next;
  logic            bus_err_reg, bus_err_next;

  EX_regs_t    cur;
  logic        is_store, access, misaligned, timeout, req, stall_int, sx;
  logic [1:0]  size;
  logic [2:0]  off;
  logic [7:0]  lane_b;
  logic [31:0] lane_w;
  logic [63:0] result;

  // Once waiting, the request is rebuilt from the captured instruction.
  always_comb begin
    cur        = (state_reg == IDLE) ? EX_regs : held_reg;
    is_store   = cur.mem_store_type != MT_NONE;
    size       = is_store ? cur.mem_store_type : cur.mem_load_type;
    access     = size != MT_NONE;
    off        = cur.out[2:0];
    misaligned = ((size == MT_WORD) && (off[1:0] != 2'b00)) ||
                 ((size == MT_DWORD) && (off != 3'b000));
  end

  always_comb begin
    mem_bus.mem_we    = is_store;
    mem_bus.mem_addr  = {cur.out[63:3], 3'b000};
    mem_bus.mem_be    = 8'hFF;
    mem_bus.mem_wdata = 64'd0;
    if (is_store) begin
      case (size)
        MT_BYTE: begin
          mem_bus.mem_be    = 8'h01 << off;
          mem_bus.mem_wdata = {8{cur.store_data[7:0]}};
        end
        MT_WORD: begin
          mem_bus.mem_be    = 8'h0F << off;
          mem_bus.mem_wdata = {2{cur.store_data[31:0]}};
        end
        default: mem_bus.mem_wdata = cur.store_data;
      endcase
    end
  end

  always_comb begin
    lane_b = mem_bus.mem_rdata[{off, 3'b000} +: 8];
    lane_w = off[2] ? mem_bus.mem_rdata[63:32] : mem_bus.mem_rdata[31:0];
    sx     = cur.signed_byte | cur.signed_word;
    case (cur.mem_load_type)
      MT_BYTE:  result = {{56{sx & lane_b[7]}}, lane_b};
      MT_WORD:  result = {{32{sx & lane_w[31]}}, lane_w};
      MT_DWORD: result = mem_bus.mem_rdata;
      default:  result = cur.out;
    endcase
    if (is_store) begin
      result = cur.out;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    held_next     = held_reg;
    data_next     = data_reg;
    regnum_next   = regnum_reg;
    wen_next      = wen_reg;
    addr_err_next = 1'b0;
    bus_err_next  = 1'b0;
    req           = 1'b0;
    stall_int     = 1'b0;
    cnt_inc       = {1'b0, cnt_reg} + (CNT_W + 1)'(1);
    timeout       = cnt_inc >= LIMIT;
    case (state_reg)
      IDLE: begin
        data_next   = cur.out;
        regnum_next = cur.W_regnum;
        wen_next    = cur.write_enable;
        if (flush) begin
          data_next   = '0;
          regnum_next = '0;
          wen_next    = 1'b0;
        end else if (access && misaligned) begin
          wen_next      = 1'b0;
          addr_err_next = 1'b1;
        end else if (access) begin
          req = 1'b1;
          if (mem_bus.mem_ready) begin
            data_next = result;
          end else begin
            stall_int  = 1'b1;
            state_next = WAIT;
            cnt_next   = '0;
            held_next  = EX_regs;
          end
        end
      end
      WAIT: begin
        req       = 1'b1;
        stall_int = 1'b1;
        if (mem_bus.mem_ready || timeout) begin
          // The transaction ends here, so EX is released in the same cycle.
          stall_int    = 1'b0;
          state_next   = IDLE;
          bus_err_next = !mem_bus.mem_ready && !flush;
          data_next    = '0;
          regnum_next  = '0;
          wen_next     = 1'b0;
          if (mem_bus.mem_ready && !flush) begin
            data_next   = result;
            regnum_next = cur.W_regnum;
            wen_next    = cur.write_enable;
          end
        end else begin
          cnt_next = cnt_inc[CNT_W-1:0];
          if (flush) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        req       = 1'b1;
        stall_int = 1'b1;
        if (mem_bus.mem_ready || timeout) begin
          stall_int   = 1'b0;
          state_next  = IDLE;
          data_next   = '0;
          regnum_next = '0;
          wen_next    = 1'b0;
        end else begin
          cnt_next = cnt_inc[CNT_W-1:0];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset also silences the request and the stall combinationally.
  assign mem_bus.mem_req = req & reset;
  assign stall           = stall_int & reset;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      held_reg     <= '0;
      data_reg     <= '0;
      regnum_reg   <= '0;
      wen_reg      <= 1'b0;
      addr_err_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      held_reg     <= held_next;
      data_reg     <= data_next;
      regnum_reg   <= regnum_next;
      wen_reg      <= wen_next;
      addr_err_reg <= addr_err_next;
      bus_err_reg  <= bus_err_next;
    end
  end

  assign MEM_data         = data_reg;
  assign MEM_W_regnum     = regnum_reg;
  assign MEM_write_enable = wen_reg;
  assign addr_err         = addr_err_reg;
  assign bus_err          = bus_err_reg;
endmodule

// File: tb/tb_core_mem.sv
// Bench for core_mem: directed corner cases followed by random loads, stores and
// ALU pass-throughs, checked against a transaction-level model of the MEM stage.
module tb_core_mem;
  import core_mem_pkg::*;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  EX_regs_t    ex;
  logic        stall, mem_wen, addr_err, bus_err;
  logic [63:0] mem_data;
  logic [4:0]  mem_regnum;

  core_mem_if bus ();

  core_mem #(.WAIT_LIMIT(LIMIT)) dut (
    .clock            (clock),
    .reset            (reset),
    .EX_regs          (ex),
    .flush            (flush),
    .mem_bus          (bus),
    .stall            (stall),
    .MEM_data         (mem_data),
    .MEM_W_regnum     (mem_regnum),
    .MEM_write_enable (mem_wen),
    .addr_err         (addr_err),
    .bus_err          (bus_err)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic EX_regs_t mk(input logic [63:0] out, input logic [63:0] sd,
                                  input logic [4:0] rn, input logic we,
                                  input logic [1:0] lt, input logic [1:0] st,
                                  input logic sb, input logic sw);
    EX_regs_t e;
    e.out = out; e.store_data = sd; e.W_regnum = rn; e.write_enable = we;
    e.mem_load_type = lt; e.mem_store_type = st; e.signed_byte = sb; e.signed_word = sw;
    return e;
  endfunction

  // Reference model: access size in bytes, natural alignment, lane arithmetic.
  function automatic int nbytes(input int size);
    return (size == 1) ? 1 : (size == 2) ? 4 : 8;
  endfunction

  function automatic logic [7:0] model_be(input int nb, input int off);
    logic [15:0] m;
    m = ((16'd1 << nb) - 16'd1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] model_wdata(input int nb, input logic [63:0] sd);
    logic [63:0] w, mask;
    w = '0;
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    for (int i = 0; i < 8 / nb; i++) w = w | ((sd & mask) << (8 * nb * i));
    return w;
  endfunction

  function automatic logic [63:0] model_load(input int nb, input int off, input bit sgn,
                                             input logic [63:0] rd);
    logic [63:0] v, mask;
    if (nb == 8) return rd;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v = (rd >> (8 * off)) & mask;
    if (sgn && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  EX_regs_t nop;

  task automatic pass(input string tag, input EX_regs_t e, input bit fl);
    ex = e; flush = fl; bus.mem_ready = 1'b0;
    #1;
    check({tag, "_req"}, bus.mem_req, 0);
    check({tag, "_stall"}, stall, 0);
    cyc();
    flush = 1'b0;
    check({tag, "_data"}, mem_data, fl ? 64'd0 : e.out);
    check({tag, "_rn"}, mem_regnum, fl ? 5'd0 : e.W_regnum);
    check({tag, "_wen"}, mem_wen, fl ? 1'b0 : e.write_enable);
    check({tag, "_aerr"}, addr_err, 0);
  endtask

  // One load/store; lat = cycles without mem_ready before it arrives.
  task automatic access(input string tag, input EX_regs_t e, input int lat,
                        input logic [63:0] rd, input bit scramble);
    bit st;
    int nb, off;
    logic [63:0] want;
    st  = e.mem_store_type != 2'd0;
    nb  = nbytes(st ? int'(e.mem_store_type) : int'(e.mem_load_type));
    off = int'(e.out[2:0]);
    ex = e; flush = 1'b0;
    if (off % nb != 0) begin
      bus.mem_ready = 1'b0;
      #1;
      check({tag, "_req"}, bus.mem_req, 0);
      check({tag, "_stall"}, stall, 0);
      cyc();
      ex = nop;
      check({tag, "_aerr"}, addr_err, 1);
      check({tag, "_wen"}, mem_wen, 0);
      cyc();
      check({tag, "_aerr_clr"}, addr_err, 0);
      return;
    end
    for (int c = 0; c <= lat; c++) begin
      bus.mem_ready = (c == lat);
      bus.mem_rdata = (c == lat) ? rd : {$urandom, $urandom};
      #1;
      check({tag, "_req"}, bus.mem_req, 1);
      check({tag, "_we"}, bus.mem_we, st);
      check({tag, "_addr"}, bus.mem_addr, {e.out[63:3], 3'b000});
      check({tag, "_be"}, bus.mem_be, st ? model_be(nb, off) : 8'hFF);
      if (st) check({tag, "_wdata"}, bus.mem_wdata, model_wdata(nb, e.store_data));
      check({tag, "_stall"}, stall, c < lat);
      cyc();
      if (scramble && c < lat) begin
        ex.out = {$urandom, $urandom};
        ex.store_data = {$urandom, $urandom};
      end
    end
    bus.mem_ready = 1'b0;
    ex = nop;
    want = st ? e.out : model_load(nb, off, e.signed_byte | e.signed_word, rd);
    check({tag, "_data"}, mem_data, want);
    check({tag, "_rn"}, mem_regnum, e.W_regnum);
    check({tag, "_wen"}, mem_wen, e.write_enable);
    check({tag, "_berr"}, bus_err, 0);
  endtask

  int kind, sz, nb, lat, reqs;
  bit sg, aln, saw_berr, retired;
  logic [63:0] a, sd, rd;

  initial begin
    nop = mk(64'd0, 64'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    ex = mk(64'h1004, 64'd0, 5'd3, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) cyc();
    check("rst_req", bus.mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_data", mem_data, 0);
    check("rst_rn", mem_regnum, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_aerr", addr_err, 0);
    check("rst_berr", bus_err, 0);
    reset = 1'b1; ex = nop;
    cyc();

    access("zw_word", mk(64'h1004, 64'd0, 5'd3, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1), 0,
           64'h80000001_00000000, 1'b0);
    check("zw_word_const", mem_data, 64'hFFFFFFFF_80000001);
    $display("txn zero-wait signed word load at 1004");

    access("st_byte", mk(64'h2003, 64'hAB, 5'd0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0), 3,
           64'd0, 1'b1);
    $display("txn byte store at 2003 with 3 wait cycles");

    access("mis_dw", mk(64'h3004, 64'd0, 5'd4, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0), 0,
           64'd0, 1'b0);
    $display("txn misaligned doubleword load at 3004");

    // Timeout: mem_ready never comes.
    pass("pre_to", mk(64'h55, 64'd0, 5'd2, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0), 1'b0);
    ex = mk(64'h4000, 64'd0, 5'd6, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    for (int c = 0; c <= LIMIT; c++) begin
      #1;
      check("to_req", bus.mem_req, 1);
      if (c < LIMIT) check("to_stall", stall, 1);
      cyc();
    end
    ex = nop;
    #1;
    check("to_req_drop", bus.mem_req, 0);
    check("to_berr", bus_err, 1);
    check("to_wen", mem_wen, 0);
    cyc();
    check("to_berr_clr", bus_err, 0);
    $display("txn load timeout after %0d wait cycles", LIMIT);

    // Flush while waiting, data arrives two cycles later.
    pass("pre_fl", mk(64'h1234, 64'd0, 5'd9, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0), 1'b0);
    ex = mk(64'h5000, 64'd0, 5'd7, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      flush = (c == 1);
      bus.mem_ready = (c == 3);
      bus.mem_rdata = {$urandom, $urandom};
      #1;
      check("fl_req", bus.mem_req, 1);
      if (c < 3) check("fl_stall", stall, 1);
      cyc();
    end
    flush = 1'b0; bus.mem_ready = 1'b0; ex = nop;
    check("fl_data", mem_data, 0);
    check("fl_rn", mem_regnum, 0);
    check("fl_wen", mem_wen, 0);
    check("fl_berr", bus_err, 0);
    #1;
    check("fl_idle_req", bus.mem_req, 0);
    check("fl_idle_stall", stall, 0);
    $display("txn flush during wait then ready");

    // Flush and ready in the same wait cycle.
    pass("pre_fr", mk(64'h777, 64'd0, 5'd11, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0), 1'b0);
    ex = mk(64'h6008, 64'd0, 5'd12, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    #1;
    cyc();
    flush = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_0000_1111;
    cyc();
    flush = 1'b0; bus.mem_ready = 1'b0; ex = nop;
    check("fr_data", mem_data, 0);
    check("fr_wen", mem_wen, 0);
    #1;
    check("fr_idle_req", bus.mem_req, 0);
    $display("txn flush with simultaneous ready");

    // Flush while waiting, ready never comes: timeout without bus_err.
    ex = mk(64'h7000, 64'd0, 5'd13, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    reqs = 0; saw_berr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      flush = (c == 1);
      #1;
      if (!bus.mem_req) break;
      reqs++;
      retired = !stall;
      cyc();
      if (bus_err) saw_berr = 1'b1;
      if (retired) ex = nop;
    end
    flush = 1'b0;
    check("dr_to_reqs", reqs, LIMIT + 1);
    check("dr_to_berr", saw_berr, 0);
    check("dr_to_wen", mem_wen, 0);
    $display("txn flush then drain timeout, %0d request cycles", reqs);

    // Reset in the middle of a wait.
    ex = mk(64'h8000, 64'd0, 5'd14, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    #1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    check("rw_req", bus.mem_req, 0);
    check("rw_stall", stall, 0);
    check("rw_data", mem_data, 0);
    reset = 1'b1; ex = nop;
    cyc();
    access("rw_byte", mk(64'h8005, 64'd0, 5'd15, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0), 1,
           64'h0000_9A00_0000_0000, 1'b0);
    $display("txn reset mid-wait then signed byte load");

    pass("idle_flush", mk(64'hCAFE, 64'd0, 5'd16, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0), 1'b1);
    $display("txn flush in idle");

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      sz   = $urandom_range(1, 3);
      nb   = nbytes(sz);
      a    = {$urandom, $urandom};
      sd   = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      sg   = $urandom_range(0, 1);
      aln  = $urandom_range(0, 4) != 0;
      lat  = $urandom_range(0, 3);
      if (aln) a[2:0] = 3'(nb * $urandom_range(0, 8 / nb - 1));
      case (kind)
        0: pass("rnd_alu", mk(a, sd, 5'($urandom), 1'($urandom), 2'd0, 2'd0, 1'b0, 1'b0), 1'b0);
        1: access("rnd_ld", mk(a, 64'd0, 5'($urandom), 1'b1, 2'(sz), 2'd0, sg, sg), lat, rd, 1'b1);
        default: access("rnd_st", mk(a, sd, 5'($urandom), 1'($urandom), 2'd0, 2'(sz), 1'b0, 1'b0),
                        lat, rd, 1'b1);
      endcase
      $display("txn %0d kind=%0d size=%0d addr=%h lat=%0d", i, kind, nb, a, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/core_mem.md
CORE_MEM -- requirements
Module: core_MEM

Interface
REQ-001 Parameter WAIT_LIMIT, default 255: maximum wait cycles for mem_ready before a bus error is raised.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the clock rising edge only.
REQ-004 EX_regs  input  EX_regs_t  execute-stage result register.
REQ-005 flush  input  1  squash the current MEM result.
REQ-006 mem_req  output  1  memory access request, level, held until accepted.
REQ-007 mem_we  output  1  store when 1, load when 0; valid while mem_req=1.
REQ-008 mem_addr  output  64  doubleword-aligned address, EX_regs.out with bits [2:0] cleared.
REQ-009 mem_be  output  8  byte enables for stores; 8'hFF for loads.
REQ-010 mem_wdata  output  64  store data, lane-replicated.
REQ-011 mem_ready  input  1  access complete; mem_rdata valid in the same cycle.
REQ-012 mem_rdata  input  64  load data, doubleword.
REQ-013 stall  output  1  freeze IF/ID/EX this cycle.
REQ-014 MEM_data  output  64  registered writeback value, also the forward source for EX.
REQ-015 MEM_W_regnum  output  5  registered destination register.
REQ-016 MEM_write_enable  output  1  registered register-file write enable.
REQ-017 addr_err  output  1  registered misaligned-access flag, one cycle per event.
REQ-018 bus_err  output  1  registered timeout flag, one cycle per event.

Function
REQ-019 Type encoding for mem_load_type and mem_store_type: 0=none, 1=byte, 2=word (32-bit), 3=doubleword.
REQ-020 Alignment rules: bytes are always aligned; words require addr[1:0]=0; doublewords require addr[2:0]=0.
REQ-021 A misaligned access issues no request, sets addr_err=1, and sets MEM_write_enable=0 for that instruction.
REQ-022 FSM states: IDLE, WAIT, DRAIN; the state is IDLE after reset.
REQ-023 In IDLE, an aligned load or store drives mem_req=1 combinationally in that cycle.
REQ-024 If mem_ready=1 in the same IDLE cycle, the result registers next edge, stall=0, and the FSM stays in IDLE (zero-wait access).
REQ-025 Otherwise stall=1 and the FSM goes to WAIT.
REQ-026 In WAIT: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held from captured values, and stall=1.
REQ-027 In WAIT, mem_ready=1 registers the result, drops stall in the same cycle, and moves the FSM to IDLE.
REQ-028 Wait counter: 8-bit or wider, cleared on entering WAIT, incremented each WAIT cycle.
REQ-029 When the wait counter reaches WAIT_LIMIT with no mem_ready: bus_err=1, MEM_write_enable=0, FSM to IDLE, mem_req drops.
REQ-030 Non-memory instructions in IDLE pass EX_regs.out, W_regnum and write_enable to the outputs with 1-cycle latency and stall=0.
REQ-031 Store lanes: byte uses be=1<<addr[2:0] with data replicated ×8; word uses be=8'h0F<<addr[2:0] with data replicated ×2; doubleword uses be=8'hFF.
REQ-032 Load extraction: select the byte or word lane by addr[2:0].
REQ-033 Load extension: sign-extend when signed_byte or signed_word is set, else zero-extend.
REQ-034 Flush in IDLE: output registers load zero next edge.
REQ-035 Flush in WAIT: FSM goes to DRAIN and keeps mem_req held, because the bus transaction is not cancellable.
REQ-036 In DRAIN: stall=1; mem_ready discards the data, zeroes the outputs, and returns the FSM to IDLE.
REQ-037 The timeout rule also applies in DRAIN, with bus_err suppressed.
REQ-038 Simultaneous flush and mem_ready in WAIT: flush wins and the outputs are zeroed.
REQ-039 addr_err and bus_err are cleared on every edge where their condition is absent.

Reset
REQ-040 When reset=0 at a rising edge: state=IDLE, counter=0, and MEM_data, MEM_W_regnum, MEM_write_enable, addr_err and bus_err are all 0.
REQ-041 While in reset, mem_req=0 and stall=0 from that edge onward.
REQ-042 Reset asserted mid-WAIT abandons the transaction, and the next access issues normally.

Verification
REQ-043 Zero-wait word load: addr 0x1004, rdata 0x80000001_00000000, signed_word=1 -> MEM_data=0xFFFFFFFF80000001 next edge, stall never 1.
REQ-044 Byte store with 3 wait cycles: addr 0x2003, data 0xAB -> be=8'h08, wdata=0xABAB..AB, mem_req held 4 cycles, stall=1 for 3 cycles.
REQ-045 Misaligned doubleword load at 0x3004 -> mem_req stays 0, addr_err=1 for one cycle, MEM_write_enable=0.
REQ-046 WAIT_LIMIT=4, mem_ready held 0 -> bus_err=1 after 4 WAIT cycles, mem_req falls, FSM returns to IDLE.
REQ-047 Flush during WAIT, then mem_ready 2 cycles later -> outputs zero, stall released only after mem_ready.
REQ-048 reset=0 mid-WAIT -> mem_req=0 and stall=0 next edge; a following byte load completes correctly.
